p_accum: RTL and testbench

//  Streaming accumulator: consumer end of the p_add operand stream. Takes LEN operands over a

---
 rtl/p_accum_pkg.sv | 22 ++
 rtl/p_accum_align.sv | 25 ++
 rtl/p_accum.sv | 73 +++++++
 tb/tb_p_accum.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/p_accum_pkg.sv
// p_accum_pkg: data formats, accumulator states and format limit helpers
package p_accum_pkg;
  typedef enum logic {INT, FXP} dtype_t;
  typedef struct packed {
    dtype_t     dtype;
    logic       sign;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;
  typedef enum logic [1:0] {IDLE, ACC, DONE} acc_state_t;
  function automatic longint fxp_max(dconf_t c);
    return c.sign ? (longint'(1) <<< (c.prec - 8'd1)) - 1 : (longint'(1) <<< c.prec) - 1;
  endfunction
  function automatic longint fxp_min(dconf_t c);
    return c.sign ? -(longint'(1) <<< (c.prec - 8'd1)) : 0;
  endfunction
  function automatic int acc_w(dconf_t i, dconf_t o, int lw);
    int a;
    a = int'(i.prec) + int'(o.frac) - int'(i.frac);
    return (a > int'(o.prec) ? a : int'(o.prec)) + lw + 1;
  endfunction
endpackage

// File: rtl/p_accum_align.sv
// p_align: combinational I_CONF->O_CONF fraction alignment into a W-bit signed word (in -> out, rounded)
module p_align
  import p_accum_pkg::*;
#(
  parameter dconf_t I_CONF = dconf_t'{FXP, 1'b1, 8'd8, 8'd3},
  parameter dconf_t O_CONF = dconf_t'{FXP, 1'b1, 8'd16, 8'd4},
  parameter int     W      = 25
) (
  input  logic [I_CONF.prec-1:0] in,
  output logic signed [W-1:0]    out,
  output logic                   rounded
);
  localparam int IP = int'(I_CONF.prec);
  localparam int SH = int'(O_CONF.frac) - int'(I_CONF.frac);
  localparam int RS = SH < 0 ? -SH : 1;
  logic signed [W-1:0] ext;
  assign ext = {{(W-IP){I_CONF.sign & in[IP-1]}}, in};
  if (SH >= 0) begin : g_l
    assign out = ext <<< SH;
    assign rounded = 1'b0;
  end else begin : g_r
    assign out = ext >>> RS;
    assign rounded = |in[RS-1:0];
  end
endmodule

// File: rtl/p_accum.sv
// p_accum: streaming saturating accumulator (start/len, in valid/ready -> out valid/ready with ovf/udf/rounded)
module p_accum
  import p_accum_pkg::*;
#(
  parameter dconf_t I_CONF = dconf_t'{FXP, 1'b1, 8'd8, 8'd3},
  parameter dconf_t O_CONF = dconf_t'{FXP, 1'b1, 8'd16, 8'd4},
  parameter int     LEN_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [I_CONF.prec-1:0] in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [O_CONF.prec-1:0] out,
  output logic                   ovf,
  output logic                   udf,
  output logic                   rounded
);
  localparam int OP = int'(O_CONF.prec);
  localparam int AW = acc_w(I_CONF, O_CONF, LEN_W);
  localparam logic signed [AW-1:0] OMAX = AW'(fxp_max(O_CONF));
  localparam logic signed [AW-1:0] OMIN = AW'(fxp_min(O_CONF));
  acc_state_t state, nstate;
  logic [LEN_W-1:0] cnt, len_q;
  logic signed [AW-1:0] acc, op, sum;
  logic [OP-1:0] sat;
  logic rnd, fire, last;
  p_align #(.I_CONF(I_CONF), .O_CONF(O_CONF), .W(AW)) u_align (.in(in), .out(op), .rounded(rnd));
  assign in_ready = state == ACC;
  assign out_valid = state == DONE;
  assign fire = in_valid && in_ready;
  assign last = fire && (cnt + 1'b1) == len_q;
  assign sum = acc + op;
  assign sat = sum > OMAX ? OMAX[OP-1:0] : sum < OMIN ? OMIN[OP-1:0] : sum[OP-1:0];
  always_comb begin
    nstate = state == IDLE ? (start ? (len == '0 ? DONE : ACC) : IDLE) :
             state == ACC  ? (last ? DONE : ACC) :
                             (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nstate;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      len_q <= '0;
      acc <= '0;
      out <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
      rounded <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      len_q <= len;
      acc <= '0;
      out <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
      rounded <= 1'b0;
    end else if (fire) begin
      cnt <= cnt + 1'b1;
      acc <= sum;
      rounded <= rounded | rnd;
      if (last) begin
        out <= sat;
        ovf <= sum > OMAX;
        udf <= sum < OMIN;
      end
    end
  end
endmodule

// File: tb/tb_p_accum.sv
// tb_p_accum: directed and random self-checking bench for p_accum
module tb_p_accum;
  import p_accum_pkg::*;
  logic clk = 1'b0;
  logic reset, start, in_valid, out_ready;
  logic [7:0] len, in;
  logic out_valid, in_ready, ovf, udf, rounded;
  logic [15:0] out;
  logic b_start, b_in_valid, b_out_ready;
  logic [7:0] b_len, b_in;
  logic b_out_valid, b_in_ready, b_ovf, b_udf, b_rounded;
  logic [15:0] b_out;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  p_accum dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .in(in), .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf), .udf(udf),
    .rounded(rounded)
  );
  p_accum #(
    .I_CONF(dconf_t'{FXP, 1'b1, 8'd8, 8'd5}),
    .O_CONF(dconf_t'{FXP, 1'b1, 8'd16, 8'd4}),
    .LEN_W(8)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .len(b_len), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in(b_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out(b_out), .ovf(b_ovf), .udf(b_udf), .rounded(b_rounded)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [7:0] l);
    start = 1'b1;
    len = l;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    in = v;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic take(input string tag, input logic [15:0] eo, input logic [2:0] ef);
    int n;
    n = 0;
    while (!out_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_out"}, 32'(out), 32'(eo));
    chk({tag, "_flags"}, 32'({ovf, udf, rounded}), 32'(ef));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'({out_valid, in_ready}), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [7:0] v;
    int l;
    real r;
    int e;
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    len = '0;
    in = '0;
    b_start = 1'b0;
    b_in_valid = 1'b0;
    b_out_ready = 1'b0;
    b_len = '0;
    b_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({out_valid, in_ready, ovf, udf, rounded, out}), 0);
    reset = 1'b0;
    @(negedge clk);
    go(8'd3);
    send(8'h1C);
    send(8'h10);
    send(8'hF6);
    chk("t1_latency", 32'(out_valid), 1);
    take("t1", 16'h0044, 3'b000);
    go(8'd0);
    chk("t2_no_ready", 32'(in_ready), 0);
    chk("t2_latency", 32'(out_valid), 1);
    take("t2", 16'h0000, 3'b000);
    go(8'd255);
    for (int i = 0; i < 255; i++) send(8'h7F);
    take("t3_ovf", 16'h7FFF, 3'b100);
    go(8'd255);
    for (int i = 0; i < 255; i++) send(8'h80);
    take("t3_udf", 16'h8000, 3'b010);
    go(8'd1);
    send(8'h08);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len = 8'd3;
      chk("t4_hold_out", 32'(out), 32'h0010);
      chk("t4_hold_state", 32'({out_valid, in_ready, ovf, udf, rounded}), 32'b10000);
      @(negedge clk);
    end
    start = 1'b1;
    len = 8'd1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4_idle_first", 32'({out_valid, in_ready}), 0);
    @(negedge clk);
    start = 1'b0;
    chk("t4_start_next", 32'(in_ready), 1);
    send(8'h08);
    take("t4", 16'h0010, 3'b000);
    go(8'd4);
    send(8'h08);
    send(8'h08);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_reset", 32'({out_valid, in_ready, ovf, udf, rounded, out}), 0);
    go(8'd2);
    send(8'h08);
    send(8'h08);
    take("t5", 16'h0020, 3'b000);
    b_start = 1'b1;
    b_len = 8'd2;
    @(negedge clk);
    b_start = 1'b0;
    b_in_valid = 1'b1;
    b_in = 8'h01;
    chk("t6_ready", 32'(b_in_ready), 1);
    @(negedge clk);
    b_in = 8'h10;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("t6_valid", 32'(b_out_valid), 1);
    chk("t6_out", 32'(b_out), 32'h0008);
    chk("t6_flags", 32'({b_ovf, b_udf, b_rounded}), 32'b001);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("t6_idle", 32'(b_out_valid), 0);
    for (int k = 0; k < 1000; k++) begin
      l = $urandom_range(1, 20);
      r = 0.0;
      go(8'(l));
      for (int j = 0; j < l; j++) begin
        v = 8'($urandom);
        r += $itor($signed(v)) / 8.0;
        send(v);
      end
      e = $rtoi(r * 16.0);
      take("rand", 16'(e), 3'b000);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
